// File: rtl/tagged_union_unpacker.sv
// Tagged int/byte union reader: holds one accepted union word and serialises
// it onto a byte-wide valid/ready stream. Int-tagged words emit every lane;
// byte-tagged words emit only the aliased low lane.
module tagged_union_unpacker #(
  parameter int unsigned NUM_BYTES = 4,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_tag,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   out_last,
  output logic [CNT_W-1:0]       word_count
);

  localparam int unsigned DATA_W = 8 * NUM_BYTES;
  localparam int unsigned IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic {IDLE, EMIT} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         byte_q, byte_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer;
  logic               last_xfer;
  logic [IDX_W-1:0]   next_idx;

  // Select the byte for emission slot idx; byte-tag words always map to lane 0.
  function automatic logic [7:0] pick_lane(input logic [DATA_W-1:0] data,
                                           input logic              tag,
                                           input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0] lane;
    logic [7:0]       b;
    lane = (MSB_FIRST && tag) ? (IDX_W'(NUM_BYTES - 1) - idx) : idx;
    b    = 8'h00;
    for (int unsigned l = 0; l < NUM_BYTES; l++) begin
      if (IDX_W'(l) == lane) b = data[8*l +: 8];
    end
    return b;
  endfunction

  // Next-state, accept and emit logic; in_ready is the only combinational output.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    xfer      = (state_q == EMIT) && out_ready;
    last_xfer = xfer && last_q;
    in_ready  = (state_q == IDLE) || last_xfer;
    next_idx  = idx_q + IDX_W'(1);

    if (last_xfer) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = IDLE;
    end else if (xfer) begin
      // Only int words reach here, so the word ends at lane NUM_BYTES-1.
      idx_d  = next_idx;
      byte_d = pick_lane(data_q, tag_q, next_idx);
      last_d = (next_idx == IDX_W'(NUM_BYTES - 1));
    end

    // Accept overrides the IDLE return so back-to-back words leave no bubble.
    if (in_valid && in_ready) begin
      state_d = EMIT;
      data_d  = in_data;
      tag_d   = in_tag;
      idx_d   = '0;
      byte_d  = pick_lane(in_data, in_tag, '0);
      last_d  = !in_tag || (NUM_BYTES == 1);
    end
  end

  // State and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      tag_q   <= 1'b0;
      idx_q   <= '0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == EMIT);
  assign out_byte   = byte_q;
  assign out_last   = last_q;
  assign word_count = cnt_q;

endmodule
